// File: rtl/aes_out_serializer.sv
// aes_out_serializer: buffers whole AES output blocks and streams them as bytes with valid/ready
module aes_out_serializer #(
  parameter int CH_NUM = 1,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               blk_i [0:CH_NUM-1][0:3][0:3],
  input  logic                     en_i,
  output logic [7:0]               data_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     last_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     ovf_o
);
  localparam int NB = CH_NUM * 16;
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(NB);
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
  localparam logic [BW-1:0] LAST = BW'(NB - 1);
  logic [7:0]    mem [0:DEPTH-1][0:NB-1];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] byte_cnt;
  logic [AW:0]   count;
  logic          load, freed, wr_ok;
  // load the output register when it is empty or draining; loading a last byte frees the head entry
  always_comb begin
    load  = (!valid_o || ready_i) && count != '0;
    freed = load && byte_cnt == LAST;
    wr_ok = en_i && (count < FULL || freed);
  end
  // block storage, flattened into stream order ch*16 + i*4 + j
  always_ff @(posedge clk)
    if (wr_ok)
      for (int c = 0; c < CH_NUM; c++)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++)
            mem[wr_ptr][c*16 + i*4 + j] <= blk_i[c][i][j];
  // pointers, byte counter, occupancy and sticky overflow
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_cnt <= '0;
      count    <= '0;
      ovf_o    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (freed) rd_ptr <= rd_ptr + AW'(1);
      if (load) byte_cnt <= freed ? '0 : byte_cnt + BW'(1);
      count <= count + (AW + 1)'(wr_ok) - (AW + 1)'(freed);
      if (en_i && !wr_ok) ovf_o <= 1'b1;
    end
  // output register stage: load, drain to idle, or hold under backpressure
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end else if (load) begin
      data_o  <= mem[rd_ptr][byte_cnt];
      last_o  <= byte_cnt == LAST;
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
    end
  assign level_o = count;
endmodule

// File: tb/tb_aes_out_serializer.sv
// tb_aes_out_serializer: directed tests of the block-to-byte serializer
module tb_aes_out_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] b1 [0:0][0:3][0:3];
  logic [7:0] b2 [0:1][0:3][0:3];
  logic       en1 = 1'b0, ready1 = 1'b0, en2 = 1'b0, ready2 = 1'b0;
  logic [7:0] data1, data2;
  logic       valid1, last1, ovf1, valid2, last2, ovf2;
  logic [2:0] level1, level2;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  aes_out_serializer #(.CH_NUM(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .blk_i(b1), .en_i(en1), .data_o(data1), .valid_o(valid1),
    .ready_i(ready1), .last_o(last1), .level_o(level1), .ovf_o(ovf1));

  aes_out_serializer #(.CH_NUM(2), .DEPTH(4)) dut2 (
    .clk(clk), .rst(rst), .blk_i(b2), .en_i(en2), .data_o(data2), .valid_o(valid2),
    .ready_i(ready2), .last_o(last2), .level_o(level2), .ovf_o(ovf2));

  task automatic set_b1(input int base, input int stride);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        b1[0][i][j] = 8'(base + stride*i + j);
  endtask

  task automatic set_b2(input int base);
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++)
          b2[c][i][j] = 8'(base + 128*c + 16*i + j);
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_reset();
    set_b1(0, 16);
    set_b2(0);
    @(negedge clk);
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid1); end
    checks++; if (data1 !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data1); end
    checks++; if (last1 !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", last1); end
    checks++; if (level1 !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", level1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf1); end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL reset_valid2 got %b want 0", valid2); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] want;
    set_b1(0, 16);
    ready1 = 1'b1;
    @(negedge clk) en1 = 1'b1;
    @(negedge clk) en1 = 1'b0;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL single_capture_valid got %b want 0", valid1); end
    checks++; if (level1 !== 3'd1) begin errors++; $display("FAIL single_capture_level got %0d want 1", level1); end
    @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      want = 8'(16*(n/4) + n%4);
      checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL single_valid[%0d] got %b want 1", n, valid1); end
      checks++; if (data1 !== want) begin errors++; $display("FAIL single_data[%0d] got %h want %h", n, data1, want); end
      checks++; if (last1 !== (n == 15)) begin errors++; $display("FAIL single_last[%0d] got %b want %b", n, last1, n == 15); end
      if (n == 0) begin
        checks++; if (level1 !== 3'd1) begin errors++; $display("FAIL single_level_first got %0d want 1", level1); end
      end
      @(negedge clk);
    end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL single_idle_valid got %b want 0", valid1); end
    checks++; if (level1 !== 3'd0) begin errors++; $display("FAIL single_idle_level got %0d want 0", level1); end
  endtask

  task automatic test_backpressure();
    logic [7:0] want, pd;
    logic       pv, pr, pl;
    int         got;
    set_b1(0, 16);
    got = 0; pv = 1'b0; pr = 1'b0; pd = '0; pl = 1'b0;
    @(negedge clk) en1 = 1'b1;
    @(negedge clk) en1 = 1'b0;
    for (int k = 0; k < 200 && got < 16; k++) begin
      if (pv && !pr) begin
        checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b want 1", valid1); end
        checks++; if (data1 !== pd) begin errors++; $display("FAIL bp_hold_data got %h want %h", data1, pd); end
        checks++; if (last1 !== pl) begin errors++; $display("FAIL bp_hold_last got %b want %b", last1, pl); end
      end
      ready1 = (k % 3 == 0);
      if (valid1 && ready1) begin
        want = 8'(16*(got/4) + got%4);
        checks++; if (data1 !== want) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", got, data1, want); end
        checks++; if (last1 !== (got == 15)) begin errors++; $display("FAIL bp_last[%0d] got %b want %b", got, last1, got == 15); end
        got++;
      end
      pv = valid1; pr = ready1; pd = data1; pl = last1;
      @(negedge clk);
    end
    checks++; if (got != 16) begin errors++; $display("FAIL bp_count got %0d want 16", got); end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL bp_idle_valid got %b want 0", valid1); end
    checks++; if (level1 !== 3'd0) begin errors++; $display("FAIL bp_idle_level got %0d want 0", level1); end
    ready1 = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] want;
    int         idx;
    ready2 = 1'b1;
    set_b2(0);
    @(negedge clk) en2 = 1'b1;
    @(negedge clk) set_b2(8'h40);
    @(negedge clk) en2 = 1'b0;
    checks++; if (level2 !== 3'd2) begin errors++; $display("FAIL b2b_level got %0d want 2", level2); end
    for (int n = 0; n < 64; n++) begin
      idx  = n % 16;
      want = 8'(64*(n/32) + 128*((n%32)/16) + 16*(idx/4) + idx%4);
      checks++; if (valid2 !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b want 1", n, valid2); end
      checks++; if (data2 !== want) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", n, data2, want); end
      checks++; if (last2 !== (n == 31 || n == 63)) begin errors++; $display("FAIL b2b_last[%0d] got %b want %b", n, last2, n == 31 || n == 63); end
      @(negedge clk);
    end
    checks++; if (valid2 !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid got %b want 0", valid2); end
    checks++; if (level2 !== 3'd0) begin errors++; $display("FAIL b2b_idle_level got %0d want 0", level2); end
  endtask

  task automatic test_overflow();
    do_reset();
    ready1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_b1(16*k, 4);
      en1 = 1'b1;
      @(negedge clk);
      if (k == 3) begin
        checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ovf_early got %b want 0", ovf1); end
      end
    end
    en1 = 1'b0;
    checks++; if (level1 !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", level1); end
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf1); end
    ready1 = 1'b1;
    for (int n = 0; n < 64; n++) begin
      checks++; if (valid1 !== 1'b1) begin errors++; $display("FAIL ovf_valid[%0d] got %b want 1", n, valid1); end
      checks++; if (data1 !== 8'(n)) begin errors++; $display("FAIL ovf_data[%0d] got %h want %h", n, data1, 8'(n)); end
      checks++; if (last1 !== (n % 16 == 15)) begin errors++; $display("FAIL ovf_last[%0d] got %b want %b", n, last1, n % 16 == 15); end
      @(negedge clk);
    end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL ovf_drained_valid got %b want 0", valid1); end
    checks++; if (level1 !== 3'd0) begin errors++; $display("FAIL ovf_drained_level got %0d want 0", level1); end
    checks++; if (ovf1 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", ovf1); end
  endtask

  task automatic test_full_free();
    do_reset();
    ready1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_b1(16*k, 4);
      en1 = 1'b1;
      @(negedge clk);
    end
    en1 = 1'b0;
    checks++; if (level1 !== 3'd4) begin errors++; $display("FAIL ff_full_level got %0d want 4", level1); end
    checks++; if (data1 !== 8'h00) begin errors++; $display("FAIL ff_head_data got %h want 00", data1); end
    ready1 = 1'b1;
    for (int m = 1; m < 15; m++) begin
      @(negedge clk);
      checks++; if (data1 !== 8'(m)) begin errors++; $display("FAIL ff_head[%0d] got %h want %h", m, data1, 8'(m)); end
    end
    set_b1(64, 4);
    en1 = 1'b1;
    @(negedge clk) en1 = 1'b0;
    checks++; if (data1 !== 8'h0f || last1 !== 1'b1) begin errors++; $display("FAIL ff_head_last got %h/%b want 0f/1", data1, last1); end
    checks++; if (level1 !== 3'd4) begin errors++; $display("FAIL ff_level got %0d want 4", level1); end
    checks++; if (ovf1 !== 1'b0) begin errors++; $display("FAIL ff_ovf got %b want 0", ovf1); end
    @(negedge clk);
    for (int n = 0; n < 64; n++) begin
      checks++; if (valid1 !== 1'b1 || data1 !== 8'(n + 16)) begin errors++; $display("FAIL ff_data[%0d] got %b/%h want 1/%h", n, valid1, data1, 8'(n + 16)); end
      @(negedge clk);
    end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL ff_idle_valid got %b want 0", valid1); end
  endtask

  task automatic test_async_reset();
    set_b1(0, 16);
    ready1 = 1'b1;
    @(negedge clk) en1 = 1'b1;
    @(negedge clk) en1 = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (valid1 !== 1'b1 || data1 !== 8'h10) begin errors++; $display("FAIL ar_pre got %b/%h want 1/10", valid1, data1); end
    #2 rst = 1'b1;
    #1;
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL ar_valid got %b want 0", valid1); end
    checks++; if (data1 !== 8'h00) begin errors++; $display("FAIL ar_data got %h want 00", data1); end
    checks++; if (last1 !== 1'b0) begin errors++; $display("FAIL ar_last got %b want 0", last1); end
    checks++; if (level1 !== 3'd0) begin errors++; $display("FAIL ar_level got %0d want 0", level1); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL ar_residual got %b want 0", valid1); end
    set_b1(8'ha0, 4);
    en1 = 1'b1;
    @(negedge clk) en1 = 1'b0;
    @(negedge clk);
    for (int n = 0; n < 16; n++) begin
      checks++; if (valid1 !== 1'b1 || data1 !== 8'(8'ha0 + n)) begin errors++; $display("FAIL ar_data[%0d] got %b/%h want 1/%h", n, valid1, data1, 8'(8'ha0 + n)); end
      checks++; if (last1 !== (n == 15)) begin errors++; $display("FAIL ar_last[%0d] got %b want %b", n, last1, n == 15); end
      @(negedge clk);
    end
    checks++; if (valid1 !== 1'b0) begin errors++; $display("FAIL ar_idle got %b want 0", valid1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_full_free();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/aes_out_serializer.md
Name: aes_out_serializer

Overview:
- Downstream neighbour of the AES-256 encryption pipeline: consumes the parallel ciphertext blocks (all channels) that the core emits on its enable strobe, and turns them into a byte stream with valid/ready flow control.
- The core has no backpressure, so this block buffers whole multi-channel blocks in a FIFO and flags any block lost to overflow.
- Sits between the AES core output and the link/DMA byte interface.

Parameters:
- CH_NUM, 1, channel count; must equal the core's channel count. Block size is CH_NUM*16 bytes.
- DEPTH, 4, FIFO depth in whole blocks; power of two, at least 2.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- blk_i  in  [7:0] x [0:CH_NUM-1][0:3][0:3]  ciphertext block, same array shape as the core output
- en_i  in  1  block-valid strobe, driven by the core's en_o; one cycle per block
- data_o  out  8  output byte
- valid_o  out  1  data_o valid
- ready_i  in  1  downstream accepts data_o
- last_o  out  1  marks the final byte of a block
- level_o  out  $clog2(DEPTH)+1  number of blocks held, including a partly streamed block
- ovf_o  out  1  sticky overflow flag

Behaviour:
- Reset, asynchronous: data_o=0, valid_o=0, last_o=0, level_o=0, ovf_o=0. Write pointer, read pointer, byte counter and FIFO count all clear. FIFO storage is not reset.
- Reset mid-stream: the partly sent block and all buffered blocks are discarded. After release the block accepts new data normally, with no residual valid_o.
- Byte order within a block:
  - Stream index n = ch*16 + i*4 + j, for blk_i[ch][i][j].
  - Channel 0 goes first; i is the outer loop, j the inner loop.
  - last_o=1 only at n = CH_NUM*16-1.
- Write side:
  - On each clk edge with en_i=1, blk_i is captured whole into FIFO[wr_ptr], wr_ptr advances modulo DEPTH, and count increments.
  - Write is accepted if count<DEPTH, or if the same edge frees an entry (read of a last byte).
  - Otherwise the block is dropped, pointers and count are unchanged, and ovf_o is set to 1. ovf_o stays 1 until rst.
  - Consecutive en_i cycles are legal; each is a separate block.
- Read side, output register stage:
  - Load condition at each edge: (valid_o==0 || ready_i==1) and count>0.
  - On load: data_o <= FIFO[rd_ptr] byte byte_cnt; last_o <= (byte_cnt==CH_NUM*16-1); valid_o <= 1; byte_cnt advances.
  - When byte_cnt wraps to 0, rd_ptr advances modulo DEPTH and count decrements at that same edge. The entry is freed when its last byte is loaded into the output register.
  - If the load condition is false and ready_i==1 with valid_o==1, then valid_o <= 0 and last_o <= 0.
  - If valid_o==1 and ready_i==0: data_o, last_o and valid_o hold unchanged.
  - A byte transfers on any edge where valid_o & ready_i.
- Latency and throughput:
  - For a capture on edge E0 into an empty FIFO with idle output, the first byte loads at E0+1, so valid_o is high after E0+1.
  - With ready_i held high, bytes are sustained at one per cycle with no bubble between blocks.
- Simultaneous write and read: count += write_accepted − entry_freed in a single update. Full with a same-cycle free accepts the write.
- level_o equals count, registered.
- Any ready_i value is legal while valid_o=0.

Test Plan:
- Single block, CH_NUM=1: blk_i[0][i][j]=8'h10*i+j, en_i for 1 cycle, ready_i=1. valid_o rises one cycle after capture; 16 consecutive bytes 00,01,02,03,10,…,33; last_o only on 33; level_o goes 1 then 0.
- Backpressure: same block, ready_i toggles 1,0,0,1,… data_o and last_o stay stable while ready_i=0; all 16 bytes arrive in order with none duplicated or lost.
- Back-to-back, CH_NUM=2: two blocks on consecutive cycles, ch1 bytes = ch0 bytes + 8'h80. 64 bytes arrive: block A ch0, block A ch1, block B…; last_o at bytes 31 and 63; no idle cycle at the block boundary.
- Overflow, DEPTH=4, ready_i=0: 5 en_i pulses. level_o=4 and ovf_o=1 after the 5th. Releasing ready_i yields exactly the first 4 blocks; ovf_o remains 1.
- Full with simultaneous free: FIFO full; en_i asserted on the same edge that loads the last byte of the head block. The write is accepted, level_o stays 4, ovf_o stays 0.
- Async reset: assert rst mid-block between clock edges. All outputs are 0 immediately; after release, a new block streams correctly from byte 0.
